// File: rtl/regfile_wr_arbiter_pkg.sv
// Register-file shared definitions: address width, register count and arbiter state encoding.
// Imported by the write arbiter, the register file and decode.
package rf_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_NREGS = 32;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request bus: NREQ requesters presenting valid/addr/data, one-hot ready back.
// Requesters hold valid/addr/data stable until they see their ready bit.
interface regfile_wr_arbiter_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) ();
  import rf_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [RF_AW*NREQ-1:0] req_addr;
  logic [XLEN*NREQ-1:0]  req_data;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);

endinterface

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester scanning from ptr upward, mod NREQ.
// Zero latency; grant is all-zero and any=0 when nothing is valid.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant_oh,
  output logic [PW-1:0]   grant_idx,
  output logic            any
);

  always_comb begin
    int            sum;
    logic [PW-1:0] idx;
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      // explicit wrap so non-power-of-two NREQ rotates correctly
      sum = int'(ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = PW'(sum);
      if (!any && req_valid[idx]) begin
        any            = 1'b1;
        grant_oh[idx]  = 1'b1;
        grant_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin share of the register-file write port; write registered one cycle after accept, x0 dropped.
// Optional RFA_ZERO_INIT_EN: 32-cycle zero sweep after reset, requesters get no ready until it ends.
module regfile_wr_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_wr_arbiter_if.slave req_bus,
  input  logic [RF_AW-1:0] ra1,
  input  logic [RF_AW-1:0] ra2,
  output logic             we,
  output logic [RF_AW-1:0] wa1,
  output logic [XLEN-1:0]  wd1,
  output logic             rd_stall,
  output logic             init_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    grant_idx;
  logic [NREQ-1:0]  grant_oh;
  logic             any;
  logic             run;
  logic             accept;
  logic [RF_AW-1:0] sel_addr;
  logic [XLEN-1:0]  sel_data;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_valid (req_bus.req_valid),
    .ptr       (ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any       (any)
  );

`ifdef RFA_ZERO_INIT_EN
  state_t           state, state_nxt;
  logic [RF_AW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) cnt <= cnt + 5'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && cnt == RF_AW'(RF_NREGS - 1)) state_nxt = ST_RUN;
  end

  assign run = (state == ST_RUN);
`else
  assign run = 1'b1;
`endif

  // rst_n gates ready so nothing is handed out while the write stage is held in reset
  assign accept            = run && rst_n && any;
  assign req_bus.req_ready = accept ? grant_oh : '0;
  assign sel_addr          = req_bus.req_addr[int'(grant_idx)*RF_AW +: RF_AW];
  assign sel_data          = req_bus.req_data[int'(grant_idx)*XLEN +: XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we  <= 1'b0;
      wa1 <= '0;
      wd1 <= '0;
      ptr <= '0;
    end else begin
      we <= 1'b0;
      if (accept) begin
        we  <= (sel_addr != '0);
        wa1 <= sel_addr;
        wd1 <= sel_data;
        ptr <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
`ifdef RFA_ZERO_INIT_EN
      if (!run) begin
        we  <= 1'b1;
        wa1 <= cnt;
        wd1 <= '0;
      end
`endif
    end
  end

  assign rd_stall  = run && we && (wa1 == ra1 || wa1 == ra2);
  assign init_done = run;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed checks of regfile_wr_arbiter against a queue-free behavioural model.
// Build with or without RFA_ZERO_INIT_EN; the sweep checks are enabled with the same macro.
module tb_regfile_wr_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

  logic [4:0]      ra1, ra2;
  logic            we;
  logic [4:0]      wa1;
  logic [XLEN-1:0] wd1;
  logic            rd_stall, init_done;

  regfile_wr_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_bus   (bus),
    .ra1       (ra1),
    .ra2       (ra2),
    .we        (we),
    .wa1       (wa1),
    .wd1       (wd1),
    .rd_stall  (rd_stall),
    .init_done (init_done)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_ptr;
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          init_left;
  int          last_g;
  bit          pv[NREQ];
  logic [4:0]  pa[NREQ];
  logic [31:0] pd[NREQ];

`ifdef RFA_ZERO_INIT_EN
  localparam int SWEEP = 32;
`else
  localparam int SWEEP = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]          = pv[i];
      bus.req_addr[5*i +: 5]    = pa[i];
      bus.req_data[32*i +: 32]  = pd[i];
    end
  endtask

  // one clock: called and returns at negedge
  task automatic cycle(input string tag);
    int              g;
    logic [NREQ-1:0] exp_rdy;
    bit              exp_stall;
    chk({tag, ".we"}, 32'(we), 32'(m_we));
    if (m_we) begin
      chk({tag, ".wa1"}, 32'(wa1), 32'(m_wa));
      chk({tag, ".wd1"}, wd1, m_wd);
    end
    chk({tag, ".init_done"}, 32'(init_done), 32'(init_left == 0));
    drive();
    #1;
    g = -1;
    if (init_left == 0)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && pv[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_stall = (init_left == 0) && m_we && (m_wa == ra1 || m_wa == ra2);
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(exp_rdy));
    chk({tag, ".rd_stall"}, 32'(rd_stall), 32'(exp_stall));
    last_g = g;
    @(posedge clk);
    if (init_left > 0) begin
      m_we = 1'b1;
      m_wa = 5'(SWEEP - init_left);
      m_wd = '0;
      init_left--;
    end else if (g >= 0) begin
      m_we  = (pa[g] != 5'd0);
      m_wa  = pa[g];
      m_wd  = pd[g];
      m_ptr = (g + 1) % NREQ;
      pv[g] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    @(negedge clk);
  endtask

  // asynchronous reset applied mid-cycle, released on a later negedge
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, ".rst_we"}, 32'(we), 32'd0);
    chk({tag, ".rst_wa1"}, 32'(wa1), 32'd0);
    chk({tag, ".rst_wd1"}, wd1, 32'd0);
    chk({tag, ".rst_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, ".rst_init_done"}, 32'(init_done), 32'(SWEEP == 0));
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    m_ptr     = 0;
    m_we      = 1'b0;
    m_wa      = '0;
    m_wd      = '0;
    init_left = SWEEP;
  endtask

  task automatic all_valid(input logic [4:0] base);
    for (int i = 0; i < NREQ; i++) begin
      if (!pv[i]) begin
        pv[i] = 1'b1;
        pa[i] = base + 5'(i);
        pd[i] = $urandom;
      end
    end
  endtask

  initial begin
    int exp_g[4];
    exp_g = '{0, 1, 2, 0};
    for (int i = 0; i < NREQ; i++) begin
      pv[i] = 1'b0; pa[i] = '0; pd[i] = '0;
    end
    ra1 = '0; ra2 = '0;
    m_ptr = 0; m_we = 0; m_wa = '0; m_wd = '0; init_left = SWEEP; last_g = -1;
    drive();
    @(negedge clk);
    all_valid(5'd5);
    drive();
    do_reset("por");

    // sweep (no-op count when the feature is absent), requests held pending throughout
    for (int c = 0; c < SWEEP; c++) cycle("sweep");

    // rotation with all three requesters continuously valid
    for (int c = 0; c < 4; c++) begin
      all_valid(5'd5);
      cycle("rot");
      chk("rot.grant", 32'(last_g), 32'(exp_g[c]));
    end

    // lone x0 write from requester 1 is consumed but not committed
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    pv[1] = 1'b1; pa[1] = 5'd0; pd[1] = 32'hDEADBEEF;
    cycle("x0");
    chk("x0.grant", 32'(last_g), 32'd1);
    all_valid(5'd12);
    cycle("x0_next");
    chk("x0.ptr_adv", 32'(last_g), 32'd2);
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    cycle("drain");

    // read collision against x9 in flight
    pv[0] = 1'b1; pa[0] = 5'd9; pd[0] = 32'h0000_0909;
    cycle("wr9");
    ra1 = 5'd0; ra2 = 5'd9;
    drive();
    #1;
    chk("stall.hit", 32'(rd_stall), 32'd1);
    ra1 = 5'd3; ra2 = 5'd4;
    #1;
    chk("stall.miss", 32'(rd_stall), 32'd0);
    cycle("stall");

    // randomized traffic
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1'b1;
          pa[i] = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
          pd[i] = $urandom;
        end
      ra1 = ($urandom_range(0, 2) == 0) ? m_wa : 5'($urandom);
      ra2 = ($urandom_range(0, 2) == 0) ? m_wa : 5'($urandom);
      cycle("rnd");
    end

    // reset during an in-flight write
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    pv[2] = 1'b1; pa[2] = 5'd10; pd[2] = 32'h1234_5678;
    cycle("pre_rst");
    do_reset("mid_run");
`ifdef RFA_ZERO_INIT_EN
    for (int c = 0; c < 12; c++) cycle("sweep_a");
    do_reset("mid_sweep");
    for (int c = 0; c < SWEEP; c++) cycle("sweep_b");
`endif
    all_valid(5'd20);
    cycle("post_rst");
    chk("post_rst.grant", 32'(last_g), 32'd0);
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    cycle("tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
